// File: rtl/pili_pkg.sv
// Shared types, mode codes, pattern lengths and lamp decode for the pili sequencer.
package pili_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLASH = 2'd2
  } state_e;

  localparam logic [1:0] MODE_CHASE_L = 2'd0;
  localparam logic [1:0] MODE_CHASE_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_FILL    = 2'd3;

  localparam logic [3:0] LEN_CHASE_L = 4'd6;
  localparam logic [3:0] LEN_CHASE_R = 4'd6;
  localparam logic [3:0] LEN_BOUNCE  = 4'd10;
  localparam logic [3:0] LEN_FILL    = 4'd7;

  // Number of steps in one pass of the selected pattern.
  function automatic logic [3:0] pattern_len(input logic [1:0] mode);
    logic [3:0] len;
    case (mode)
      MODE_CHASE_L: len = LEN_CHASE_L;
      MODE_CHASE_R: len = LEN_CHASE_R;
      MODE_BOUNCE:  len = LEN_BOUNCE;
      default:      len = LEN_FILL;
    endcase
    return len;
  endfunction

  // Lamp vector {F,E,D,C,B,A} for a pattern step.
  function automatic logic [5:0] lamp_decode(input logic [1:0] mode, input logic [3:0] q);
    logic [5:0] lamps;
    case (mode)
      MODE_CHASE_L: lamps = 6'b000001 << q;
      MODE_CHASE_R: lamps = 6'b100000 >> q;
      // Steps 6..9 walk back down from E to B: lamp index 10-q.
      MODE_BOUNCE:  lamps = (q < 4'd6) ? (6'b000001 << q) : (6'b000001 << (4'd10 - q));
      default:      lamps = ~(6'b111111 << q);
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/pili_tick.sv
// Step-tick prescaler: pulses tick once every (TICK_DIV << speed) clock cycles.
module pili_tick #(
  parameter int TICK_DIV = 2
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  // Wide enough for the count at the slowest speed (TICK_DIV*8 - 1).
  localparam int CNT_W = $clog2(TICK_DIV * 8);
  localparam logic [CNT_W:0] BASE = (CNT_W + 1)'(TICK_DIV);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   period;
  logic [CNT_W-1:0] cnt_max;

  // Terminal count for the latched speed and the tick decode.
  always_comb begin
    period  = BASE << speed;
    cnt_max = CNT_W'(period - (CNT_W + 1)'(1));
    tick    = (count_q == cnt_max);
  end

  // Next count: restart on clear or after the terminal count.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pili_ctrl.sv
// Running-light sequencer: paces the step counter, decodes lamp patterns,
// runs PASSES passes, an end flash, then returns idle with a Done pulse.
module pili_ctrl #(
  parameter int TICK_DIV    = 2,
  parameter int PASSES      = 2,
  parameter int FLASH_TICKS = 4
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Start,
  input  logic       Stop,
  input  logic [1:0] Mode,
  input  logic [1:0] Speed,
  output logic [3:0] Q,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       Busy,
  output logic       Done
);

  import pili_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] q_q, q_d;
  logic [3:0] pass_q, pass_d;
  logic [3:0] flash_q, flash_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] speed_q, speed_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       tick;
  logic       tick_clear;
  logic       last_step;
  logic       last_pass;
  logic       last_flash;
  logic [5:0] lamps;

  // Prescaler held at zero while idle and restarted on every state change,
  // so each RUN and FLASH phase starts with a full tick period.
  assign tick_clear = (state_q == ST_IDLE) || (state_d != state_q);

  pili_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .Clk  (Clk),
    .Clr  (Clr),
    .clear(tick_clear),
    .speed(speed_q),
    .tick (tick)
  );

  assign last_step  = (q_q == pattern_len(mode_q) - 4'd1);
  assign last_pass  = (pass_q == 4'(PASSES - 1));
  assign last_flash = (flash_q == 4'(FLASH_TICKS - 1));

  // State register and datapath registers.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      pass_q  <= '0;
      flash_q <= '0;
      mode_q  <= MODE_CHASE_L;
      speed_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pass_q  <= pass_d;
      flash_q <= flash_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; Stop wins over any coincident tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (Stop) state_d = ST_IDLE;
        else if (tick && last_step && last_pass) state_d = ST_FLASH;
      end
      ST_FLASH: begin
        if (Stop) state_d = ST_IDLE;
        else if (tick && last_flash) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Step, pass and flash counters, launch-time latches, Busy/Done.
  always_comb begin
    q_d     = q_q;
    pass_d  = pass_q;
    flash_d = flash_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        q_d     = '0;
        flash_d = '0;
        if (Start && !Stop) begin
          mode_d  = Mode;
          speed_d = Speed;
          pass_d  = '0;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          q_d = '0;
        end else if (tick) begin
          if (last_step) begin
            q_d     = '0;
            pass_d  = pass_q + 4'd1;
            flash_d = '0;
          end else begin
            q_d = q_q + 4'd1;
          end
        end
      end
      ST_FLASH: begin
        q_d = '0;
        if (!Stop && tick) begin
          if (last_flash) done_d = 1'b1;
          else flash_d = flash_q + 4'd1;
        end
      end
      default: begin
        q_d     = '0;
        flash_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Lamp outputs from registered state, step and latched mode.
  always_comb begin
    lamps = '0;
    case (state_q)
      ST_RUN:   lamps = lamp_decode(mode_q, q_q);
      ST_FLASH: lamps = flash_q[0] ? 6'b000000 : 6'b111111;
      default:  lamps = '0;
    endcase
  end

  assign {F, E, D, C, B, A} = lamps;
  assign Q    = q_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_pili_ctrl.sv
// Bench for pili_ctrl: randomized shows checked against a per-cycle expected trace.
`timescale 1ns/1ps
module tb_pili_ctrl;

  localparam int TICK_DIV    = 2;
  localparam int PASSES      = 2;
  localparam int FLASH_TICKS = 4;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic [1:0] Speed = 2'd0;
  logic [3:0] Q;
  logic       A, B, C, D, E, F;
  logic       Busy, Done;
  logic [5:0] lamps_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         q;
    logic [5:0] l;
    bit         busy;
    bit         done;
  } step_t;

  step_t exp_q[$];
  int    run_len;
  int    flash_len;

  pili_ctrl #(
    .TICK_DIV(TICK_DIV),
    .PASSES(PASSES),
    .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Stop(Stop), .Mode(Mode), .Speed(Speed),
    .Q(Q), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .Busy(Busy), .Done(Done)
  );

  assign lamps_obs = {F, E, D, C, B, A};

  always #100 Clk = ~Clk;

  function automatic int ref_len(input int m);
    if (m == 2) return 10;
    if (m == 3) return 7;
    return 6;
  endfunction

  // Which lamps are lit at a given step, lamp i = 0 for A .. 5 for F.
  function automatic logic [5:0] ref_lamps(input int m, input int st);
    logic [5:0] v;
    int         pos;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      case (m)
        0: v[i] = (i == st);
        1: v[i] = (i == 5 - st);
        2: begin
          pos  = (st <= 5) ? st : 10 - st;
          v[i] = (i == pos);
        end
        default: v[i] = (i < st);
      endcase
    end
    return v;
  endfunction

  // Expected per-cycle outputs of one show, starting at the first RUN cycle.
  task automatic build_trace(input int m, input int sp, input bit tail);
    int per;
    per = TICK_DIV << sp;
    exp_q.delete();
    for (int p = 0; p < PASSES; p++)
      for (int st = 0; st < ref_len(m); st++)
        for (int c = 0; c < per; c++)
          exp_q.push_back('{st, ref_lamps(m, st), 1'b1, 1'b0});
    run_len = exp_q.size();
    for (int k = 0; k < FLASH_TICKS; k++)
      for (int c = 0; c < per; c++)
        exp_q.push_back('{0, (k % 2 == 0) ? 6'h3f : 6'h00, 1'b1, 1'b0});
    flash_len = exp_q.size() - run_len;
    exp_q.push_back('{0, 6'h00, 1'b0, 1'b1});
    if (tail) exp_q.push_back('{0, 6'h00, 1'b0, 1'b0});
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #250;
    checks += 4;
    if (Q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", Q); end
    if (lamps_obs !== 6'h00) begin errors++; $display("FAIL reset_lamps got %b want 000000", lamps_obs); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    #35;
    Clr = 1'b1;
    cyc();
  endtask

  // Full shows with Mode/Speed/Start wiggled randomly while busy.
  task automatic test_patterns();
    int m, sp;
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: begin m = 0; sp = 0; end
        1: begin m = 2; sp = 1; end
        2: begin m = 3; sp = 0; end
        3: begin m = 1; sp = 0; end
        default: begin m = $urandom_range(0, 3); sp = $urandom_range(0, 3); end
      endcase
      build_trace(m, sp, 1'b1);
      Mode = 2'(m); Speed = 2'(sp); Start = 1'b1;
      cyc();
      Start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks += 4;
        if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL pat_q m%0d s%0d [%0d] got %0d want %0d", m, sp, i, Q, exp_q[i].q); end
        if (lamps_obs !== exp_q[i].l) begin errors++; $display("FAIL pat_lamps m%0d s%0d [%0d] got %b want %b", m, sp, i, lamps_obs, exp_q[i].l); end
        if (Busy !== exp_q[i].busy) begin errors++; $display("FAIL pat_busy m%0d s%0d [%0d] got %b want %b", m, sp, i, Busy, exp_q[i].busy); end
        if (Done !== exp_q[i].done) begin errors++; $display("FAIL pat_done m%0d s%0d [%0d] got %b want %b", m, sp, i, Done, exp_q[i].done); end
        if (exp_q[i].busy) begin
          Mode = 2'($urandom); Speed = 2'($urandom); Start = 1'($urandom);
        end else begin
          Start = 1'b0;
        end
        cyc();
      end
    end
  endtask

  // Abort mid-RUN (at Q=3, mode 1) and mid-FLASH; then Start+Stop together in IDLE.
  task automatic test_stop();
    int m, sp, stop_idx;
    for (int s = 0; s < 2; s++) begin
      m  = (s == 0) ? 1 : $urandom_range(0, 3);
      sp = (s == 0) ? 0 : $urandom_range(0, 1);
      build_trace(m, sp, 1'b0);
      stop_idx = run_len + $urandom_range(0, flash_len - 1);
      if (s == 0) begin
        stop_idx = 0;
        while (exp_q[stop_idx].q != 3) stop_idx++;
      end
      Mode = 2'(m); Speed = 2'(sp); Start = 1'b1;
      cyc();
      Start = 1'b0;
      for (int i = 0; i <= stop_idx; i++) begin
        checks += 2;
        if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL stop_pre_q [%0d] got %0d want %0d", i, Q, exp_q[i].q); end
        if (lamps_obs !== exp_q[i].l) begin errors++; $display("FAIL stop_pre_lamps [%0d] got %b want %b", i, lamps_obs, exp_q[i].l); end
        if (i == stop_idx) Stop = 1'b1;
        cyc();
      end
      Stop = 1'b0;
      checks += 4;
      if (Q !== 4'd0) begin errors++; $display("FAIL stop_q s%0d got %0d want 0", s, Q); end
      if (lamps_obs !== 6'h00) begin errors++; $display("FAIL stop_lamps s%0d got %b want 000000", s, lamps_obs); end
      if (Busy !== 1'b0) begin errors++; $display("FAIL stop_busy s%0d got %b want 0", s, Busy); end
      if (Done !== 1'b0) begin errors++; $display("FAIL stop_done s%0d got %b want 0", s, Done); end
      cyc();
      checks += 2;
      if (Done !== 1'b0) begin errors++; $display("FAIL stop_done_after s%0d got %b want 0", s, Done); end
      if (Busy !== 1'b0) begin errors++; $display("FAIL stop_busy_after s%0d got %b want 0", s, Busy); end
    end
    Start = 1'b1; Stop = 1'b1;
    cyc();
    Start = 1'b0; Stop = 1'b0;
    checks += 2;
    if (Busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got %b want 0", Busy); end
    if (Q !== 4'd0) begin errors++; $display("FAIL start_stop_q got %0d want 0", Q); end
    cyc();
    checks += 1;
    if (Busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy_after got %b want 0", Busy); end
  endtask

  // Clear dropped mid-FLASH takes effect without a clock edge; relaunch afterwards.
  task automatic test_clr_flash();
    int m, sp, clr_idx;
    m  = $urandom_range(0, 3);
    sp = 0;
    build_trace(m, sp, 1'b0);
    clr_idx = run_len + $urandom_range(0, flash_len - 1);
    Mode = 2'(m); Speed = 2'(sp); Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i <= clr_idx; i++) begin
      checks += 2;
      if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL clr_pre_q [%0d] got %0d want %0d", i, Q, exp_q[i].q); end
      if (Busy !== exp_q[i].busy) begin errors++; $display("FAIL clr_pre_busy [%0d] got %b want %b", i, Busy, exp_q[i].busy); end
      if (i < clr_idx) cyc();
    end
    #50;
    Clr = 1'b0;
    #10;
    checks += 4;
    if (Q !== 4'd0) begin errors++; $display("FAIL clr_q got %0d want 0", Q); end
    if (lamps_obs !== 6'h00) begin errors++; $display("FAIL clr_lamps got %b want 000000", lamps_obs); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL clr_done got %b want 0", Done); end
    cyc();
    Clr = 1'b1;
    m  = $urandom_range(0, 3);
    sp = $urandom_range(0, 1);
    build_trace(m, sp, 1'b1);
    Mode = 2'(m); Speed = 2'(sp); Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks += 4;
      if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL relaunch_q [%0d] got %0d want %0d", i, Q, exp_q[i].q); end
      if (lamps_obs !== exp_q[i].l) begin errors++; $display("FAIL relaunch_lamps [%0d] got %b want %b", i, lamps_obs, exp_q[i].l); end
      if (Busy !== exp_q[i].busy) begin errors++; $display("FAIL relaunch_busy [%0d] got %b want %b", i, Busy, exp_q[i].busy); end
      if (Done !== exp_q[i].done) begin errors++; $display("FAIL relaunch_done [%0d] got %b want %b", i, Done, exp_q[i].done); end
      cyc();
    end
  endtask

  // Start held high: Done pulses in a single IDLE cycle, then the next show begins.
  task automatic test_back_to_back();
    int m;
    m = $urandom_range(0, 3);
    build_trace(m, 0, 1'b1);
    Mode = 2'(m); Speed = 2'd0; Start = 1'b1;
    cyc();
    for (int i = 0; i < exp_q.size() - 1; i++) begin
      checks += 3;
      if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL b2b1_q [%0d] got %0d want %0d", i, Q, exp_q[i].q); end
      if (Busy !== exp_q[i].busy) begin errors++; $display("FAIL b2b1_busy [%0d] got %b want %b", i, Busy, exp_q[i].busy); end
      if (Done !== exp_q[i].done) begin errors++; $display("FAIL b2b1_done [%0d] got %b want %b", i, Done, exp_q[i].done); end
      cyc();
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks += 4;
      if (Q !== 4'(exp_q[i].q)) begin errors++; $display("FAIL b2b2_q [%0d] got %0d want %0d", i, Q, exp_q[i].q); end
      if (lamps_obs !== exp_q[i].l) begin errors++; $display("FAIL b2b2_lamps [%0d] got %b want %b", i, lamps_obs, exp_q[i].l); end
      if (Busy !== exp_q[i].busy) begin errors++; $display("FAIL b2b2_busy [%0d] got %b want %b", i, Busy, exp_q[i].busy); end
      if (Done !== exp_q[i].done) begin errors++; $display("FAIL b2b2_done [%0d] got %b want %b", i, Done, exp_q[i].done); end
      Start = 1'b0;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stop();
    test_clr_flash();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
